// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the uart_sender transmitter.
//   uart_state_e          : transmitter FSM state encoding
//   DEFAULT_CLKS_PER_BIT  : 100 MHz / 115200 baud
//   DATA_BITS             : payload bits per frame
//   FRAME_BITS_8N1        : start + 8 data + stop
//   FRAME_BITS_PARITY     : start + 8 data + parity + stop
//   FRAME_BITS            : frame length of the current build
//   even_parity()         : XOR of the data bits
// Optional feature macro: UART_SENDER_PARITY_EN (adds an even-parity bit).
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS_8N1       = 10;
  localparam int FRAME_BITS_PARITY    = 11;

`ifdef UART_SENDER_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
  localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer for uart_sender. Counts 0..CLKS_PER_BIT-1 while enabled and
// raises bit_done for one cycle on the last count of every bit period.
//   clock    : system clock
//   reset_n  : asynchronous active-low reset
//   clear    : restart the bit period (frame acceptance)
//   enable   : count while a frame is in flight
//   bit_done : one-cycle pulse, current bit period has elapsed
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear takes priority so an acceptance never sees a stale boundary.
  assign bit_done = enable && !clear && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_sender.sv
// -----------------------------------------------------------------------------
// uart_sender
// Byte-wide asynchronous serial transmitter: 8N1, LSB first, idle-high line.
// A byte is accepted on any rising edge in IDLE with start=1; busy stays high
// until the stop bit has lasted a full bit period.
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   clock        : system clock, all state on rising edge
//   reset_n      : asynchronous active-low reset
//   start        : transmit request, level-sampled while idle
//   data[7:0]    : byte to send, captured on the accepting edge
//   busy         : high from acceptance until the stop bit completes
//   out          : serial TX line (idle/stop = 1)
// Optional feature macro: UART_SENDER_PARITY_EN inserts an even-parity bit
// between data bit 7 and the stop bit (11 bit times per frame).
// -----------------------------------------------------------------------------
module uart_sender
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 out
);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 parity_q, parity_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;

  logic accept;
  logic bit_done;

  assign accept = (state_q == ST_IDLE) && start;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (accept),
    .enable   (state_q != ST_IDLE),
    .bit_done (bit_done)
  );

  // State and output registers. out/busy are registered from the next-state
  // values so the pins change on the same edge as the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      out_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_START;
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done && (bit_idx_q == 3'd7)) begin
`ifdef UART_SENDER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;

    if (accept) begin
      shift_d   = data;
      bit_idx_d = 3'd0;
      parity_d  = even_parity(data);
    end else if ((state_q == ST_DATA) && bit_done) begin
      shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    busy_d = (state_d != ST_IDLE);

    // The line level is derived from the state being entered, so shift_d[0]
    // is already the bit that belongs to the next bit period.
    unique case (state_d)
      ST_IDLE:   out_d = 1'b1;
      ST_START:  out_d = 1'b0;
      ST_DATA:   out_d = shift_d[0];
      ST_PARITY: out_d = parity_d;
      ST_STOP:   out_d = 1'b1;
      default:   out_d = 1'b1;
    endcase
  end

  assign busy = busy_q;
  assign out  = out_q;

endmodule

// File: tb/tb_uart_sender.sv
// -----------------------------------------------------------------------------
// tb_uart_sender
// Self-checking bench for uart_sender with CLKS_PER_BIT = 4. A per-cycle
// frame-level reference model predicts out/busy; a line monitor decodes each
// frame into a record for the table, corner-case and random tests.
// -----------------------------------------------------------------------------
module tb_uart_sender;
  import uart_pkg::*;

  localparam int C = 4;
`ifdef UART_SENDER_PARITY_EN
  localparam int FB = FRAME_BITS_PARITY;
`else
  localparam int FB = FRAME_BITS_8N1;
`endif
  localparam int FLEN = FB * C;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] data    = 8'h00;
  logic       busy;
  logic       out;

  int checks = 0;
  int errors = 0;

  uart_sender #(.CLKS_PER_BIT(C)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .data    (data),
    .busy    (busy),
    .out     (out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: whole-frame bit vector ----------------
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (FB == 11) f[9] = ^b;
    return f;
  endfunction

  logic        m_busy  = 1'b0;
  int          m_pos   = 0;
  logic [10:0] m_frame = '1;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_pos  <= 0;
    end else if (m_busy) begin
      m_pos <= m_pos + 1;
      if (m_pos + 1 == FLEN) m_busy <= 1'b0;
    end else if (start) begin
      m_busy  <= 1'b1;
      m_pos   <= 0;
      m_frame <= frame_of(data);
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_out", 32'(out), m_busy ? 32'(m_frame[m_pos / C]) : 32'd1);
    end
  end

  // ---------------- line monitor ----------------
  typedef struct {
    logic [7:0] b;
    int         len;
    int         gap;
    logic       start_ok;
    logic       stop_ok;
    logic       par;
  } rec_t;

  rec_t recs[$];

  initial begin
    logic prev_busy;
    int   cnt;
    int   idle_cnt;
    int   gap;
    logic samp[FLEN];
    rec_t r;
    prev_busy = 1'b0;
    cnt = 0;
    idle_cnt = 0;
    gap = 0;
    forever begin
      @(negedge clock);
      if (busy === 1'b1) begin
        if (!prev_busy) begin
          cnt = 0;
          gap = idle_cnt;
        end
        if (cnt < FLEN) samp[cnt] = out;
        cnt++;
      end else begin
        if (prev_busy) begin
          for (int i = 0; i < 8; i++) r.b[i] = samp[(i + 1) * C + C / 2];
          r.len      = cnt;
          r.gap      = gap;
          r.start_ok = (samp[C / 2] == 1'b0);
          r.stop_ok  = (samp[(FB - 1) * C + C / 2] == 1'b1);
          r.par      = samp[9 * C + C / 2];
          recs.push_back(r);
          idle_cnt = 0;
        end
        idle_cnt++;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_frames(input int n, input int limit);
    int k;
    k = 0;
    while (recs.size() < n && k < limit) begin
      @(negedge clock);
      k++;
    end
    chk("wait_frames", 32'(recs.size() >= n), 32'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_busy(input logic lvl, input int limit);
    int k;
    k = 0;
    while (busy !== lvl && k < limit) begin
      @(negedge clock);
      k++;
    end
    chk("wait_busy", 32'(busy), 32'(lvl));
  endtask

  // ---------------- table of single-frame vectors ----------------
  typedef struct {
    logic [7:0] d;
    int         slen;
    int         chg_at;
    logic [7:0] chg_d;
    logic [7:0] exp_b;
    logic       exp_par;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [7:0] sent[$];
    int         busy_cnt;

    vt[0] = '{8'h55, 1, 0, 8'h00, 8'h55, 1'b0};
    vt[1] = '{8'h1B, 3, 2, 8'h00, 8'h1B, 1'b0};
    vt[2] = '{8'h00, 2, 1, 8'hFF, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 1, 0, 8'h00, 8'hFF, 1'b0};
    vt[4] = '{8'h07, 1, 0, 8'h00, 8'h07, 1'b1};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_out", 32'(out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      recs.delete();
      data  = vt[v].d;
      start = 1'b1;
      for (int cyc = 1; cyc <= vt[v].slen; cyc++) begin
        @(negedge clock);
        if (cyc == vt[v].chg_at) data = vt[v].chg_d;
        if (cyc == vt[v].slen) start = 1'b0;
      end
      wait_frames(1, FLEN + 50);
      repeat (FLEN) @(negedge clock);
      chk("vec_nframes", 32'(recs.size()), 32'd1);
      chk("vec_byte", 32'(recs[0].b), 32'(vt[v].exp_b));
      chk("vec_busy_len", 32'(recs[0].len), 32'(FLEN));
      chk("vec_start_bit", 32'(recs[0].start_ok), 32'd1);
      chk("vec_stop_bit", 32'(recs[0].stop_ok), 32'd1);
`ifdef UART_SENDER_PARITY_EN
      chk("vec_parity", 32'(recs[0].par), 32'(vt[v].exp_par));
`endif
      $display("vec %0d: data=%02h sent=%02h busy_len=%0d", v, vt[v].d, recs[0].b, recs[0].len);
    end

    // start held high: back-to-back frames with one idle cycle
    recs.delete();
    data  = 8'hFE;
    start = 1'b1;
    wait_busy(1'b1, 10);
    wait_busy(1'b0, FLEN + 10);
    wait_busy(1'b1, 10);
    start = 1'b0;
    wait_frames(2, 2 * FLEN + 50);
    repeat (FLEN) @(negedge clock);
    chk("b2b_nframes", 32'(recs.size()), 32'd2);
    chk("b2b_byte0", 32'(recs[0].b), 32'hFE);
    chk("b2b_byte1", 32'(recs[1].b), 32'hFE);
    chk("b2b_gap", 32'(recs[1].gap), 32'd1);
    chk("b2b_len1", 32'(recs[1].len), 32'(FLEN));
    $display("b2b: frames=%0d gap=%0d", recs.size(), recs[1].gap);

    // start pulsed mid-frame is ignored
    recs.delete();
    data  = 8'h3C;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (15) @(negedge clock);
    data  = 8'h99;
    start = 1'b1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    wait_frames(1, FLEN + 50);
    repeat (FLEN) @(negedge clock);
    chk("mid_nframes", 32'(recs.size()), 32'd1);
    chk("mid_byte", 32'(recs[0].b), 32'h3C);
    chk("mid_len", 32'(recs[0].len), 32'(FLEN));
    $display("midstart: frames=%0d byte=%02h", recs.size(), recs[0].b);

    // asynchronous reset mid-frame
    data  = 8'hFF;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (12) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n  = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < FLEN + 10; i++) begin
      @(negedge clock);
      if (busy !== 1'b0) busy_cnt++;
    end
    chk("arst_no_residual", 32'(busy_cnt), 32'd0);
    $display("reset: busy cycles after release=%0d", busy_cnt);

    // randomized frames
    recs.delete();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      wait_busy(1'b0, FLEN + 10);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      d     = 8'($urandom);
      data  = d;
      start = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clock);
      start = 1'b0;
      data  = 8'($urandom);
      sent.push_back(d);
      $display("rnd %0d: data=%02h", i, d);
    end
    wait_frames(20, FLEN + 50);
    chk("rnd_nframes", 32'(recs.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      chk("rnd_byte", 32'(recs[i].b), 32'(sent[i]));
      chk("rnd_len", 32'(recs[i].len), 32'(FLEN));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
